// File: rtl/spi_ctrl_pkg.sv
// ============================================================================
//  Module   : spi_ctrl_pkg
//  Purpose  : Shared state encodings and sizing helper for spi_xfer_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_ctrl_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  // Bits needed to index 'value' distinct items; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
// ============================================================================
//  Module   : spi_rr_arbiter
//  Purpose  : Combinational round-robin pick: first request at or after ptr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  logic [PW-1:0] w_idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        any           = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
// ============================================================================
//  Module   : spi_xfer_arbiter
//  Purpose  : Round-robin sharing of one SPI shift engine among NREQ requesters,
//             with per-slave chip-select setup/hold sequencing.
//  Options  : SPI_TIMEOUT_EN - adds a TMO_CYC-cycle watchdog in XFER.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int LENGTH   = 8,
  parameter int NREQ     = 4,
  parameter int NSLV     = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 1,
  parameter int TMO_CYC  = 64,
  localparam int SLV_W   = (NSLV > 1) ? clog2(NSLV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LENGTH-1:0]  req_data,
  input  logic [NREQ*SLV_W-1:0]   req_slv,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [LENGTH-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [NSLV-1:0]         cs_n,
  output logic [LENGTH-1:0]       m_d_in,
  output logic                    m_start,
  input  logic                    m_done,
  input  logic [LENGTH-1:0]       m_d_rec
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int MAXV_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAXV_B = (MAXV_A > IDLE_GAP) ? MAXV_A : IDLE_GAP;
`ifdef SPI_TIMEOUT_EN
  localparam int MAXV   = (MAXV_B > TMO_CYC) ? MAXV_B : TMO_CYC;
`else
  localparam int MAXV   = MAXV_B;
`endif
  localparam int CW = clog2(MAXV + 1);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [LENGTH-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [NSLV-1:0]   r_cs_n;
  logic [LENGTH-1:0] r_m_d_in;
  logic              r_m_start;

  logic [NREQ-1:0]   w_win_oh;
  logic              w_any;
  logic [PW-1:0]     w_win_idx;
  logic [PW-1:0]     w_ptr_nxt;
  logic [LENGTH-1:0] w_win_data;
  logic [SLV_W-1:0]  w_win_slv;
  logic              w_slv_ok;

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win_oh),
    .any    (w_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) w_win_idx = PW'(i);
    end
  end

  assign w_ptr_nxt  = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + PW'(1);
  assign w_win_data = req_data[int'(w_win_idx)*LENGTH +: LENGTH];
  assign w_win_slv  = req_slv[int'(w_win_idx)*SLV_W +: SLV_W];
  assign w_slv_ok   = int'(w_win_slv) < NSLV;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_cs_n     <= '1;
      r_m_d_in   <= '0;
      r_m_start  <= 1'b0;
    end else begin
      r_ack     <= '0;
      r_m_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt    <= w_win_oh;
            r_m_d_in <= w_win_data;
            r_ptr    <= w_ptr_nxt;
            if (w_slv_ok) begin
              r_cs_n <= ~(NSLV'(1) << w_win_slv);
              if (CS_SETUP == 0) begin
                r_m_start <= 1'b1;
                r_state   <= XFER;
                r_cnt     <= '0;
              end else begin
                r_state <= SETUP;
                r_cnt   <= CW'(CS_SETUP);
              end
            end else begin
              // Unreachable slave: complete immediately with an error, bus untouched.
              r_ack     <= w_win_oh;
              r_rsp_err <= 1'b1;
              r_state   <= GAP;
              r_cnt     <= CW'(IDLE_GAP);
            end
          end
        end
        SETUP: begin
          if (r_cnt == CW'(1)) begin
            r_m_start <= 1'b1;
            r_state   <= XFER;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        XFER: begin
          if (m_done) begin
            r_rsp_data <= m_d_rec;
            if (CS_HOLD == 0) begin
              r_cs_n    <= '1;
              r_ack     <= r_gnt;
              r_rsp_err <= 1'b0;
              r_state   <= GAP;
              r_cnt     <= CW'(IDLE_GAP);
            end else begin
              r_state <= HOLD;
              r_cnt   <= CW'(CS_HOLD);
            end
          end
`ifdef SPI_TIMEOUT_EN
          else if (r_cnt == CW'(TMO_CYC - 1)) begin
            r_cs_n    <= '1;
            r_ack     <= r_gnt;
            r_rsp_err <= 1'b1;
            r_state   <= GAP;
            r_cnt     <= CW'(IDLE_GAP);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        HOLD: begin
          if (r_cnt == CW'(1)) begin
            r_cs_n    <= '1;
            r_ack     <= r_gnt;
            r_rsp_err <= 1'b0;
            r_state   <= GAP;
            r_cnt     <= CW'(IDLE_GAP);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        GAP: begin
          // GAP begins in the ack cycle, so gnt falls right after it.
          r_gnt <= '0;
          if (r_cnt <= CW'(1)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_cs_n  <= '1;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign cs_n     = r_cs_n;
  assign m_d_in   = r_m_d_in;
  assign m_start  = r_m_start;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
// ============================================================================
//  Module   : tb_spi_xfer_arbiter
//  Purpose  : Directed self-checking bench for spi_xfer_arbiter (NSLV=5).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_xfer_arbiter;

  localparam int LENGTH  = 8;
  localparam int NREQ    = 4;
  localparam int NSLV    = 5;
  localparam int SLV_W   = 3;
  localparam int TMO_CYC = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*LENGTH-1:0] req_data;
  logic [NREQ*SLV_W-1:0]  req_slv;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [LENGTH-1:0]      rsp_data;
  logic                   rsp_err;
  logic [NSLV-1:0]        cs_n;
  logic [LENGTH-1:0]      m_d_in;
  logic                   m_start;
  logic                   m_done;
  logic [LENGTH-1:0]      m_d_rec;

  int checks = 0;
  int errors = 0;
  int n_start, n_cs_low, n_ack;
  int eng_cnt, eng_lat;
  bit eng_on, eng_spur;
  logic [LENGTH-1:0] eng_rx;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .LENGTH(LENGTH), .NREQ(NREQ), .NSLV(NSLV),
    .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(1), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_slv(req_slv),
    .gnt(gnt), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .cs_n(cs_n),
    .m_d_in(m_d_in), .m_start(m_start), .m_done(m_done), .m_d_rec(m_d_rec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: observe outputs at negedge, then advance the engine model.
  task automatic step();
    @(negedge clk);
    if (m_start) n_start++;
    if (cs_n !== '1) n_cs_low++;
    if (ack !== '0) n_ack++;
    m_done  = 1'b0;
    m_d_rec = 8'hEE;
    if (eng_spur) begin
      m_done   = 1'b1;
      m_d_rec  = eng_rx;
      eng_spur = 1'b0;
    end else if (m_start && eng_on) begin
      eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        m_done  = 1'b1;
        m_d_rec = eng_rx;
      end
    end
  endtask

  task automatic until_ack(input string tag, input int budget, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step();
      n++;
      if (ack !== '0) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic until_start(input string tag, input int budget);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step();
      n++;
      if (m_start === 1'b1) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int n, hi, exp_i;
    bit got;
    int order [5] = '{0, 1, 2, 3, 0};

    rst = 1'b0; req = '0; req_data = '0; req_slv = '0;
    m_done = 1'b0; m_d_rec = '0;
    n_start = 0; n_cs_low = 0; n_ack = 0;
    eng_cnt = 0; eng_lat = 7; eng_on = 1'b1; eng_spur = 1'b0; eng_rx = '0;

    // Reset values
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h1F);
    chk("rst_m_start", 32'(m_start), 32'h0);
    chk("rst_m_d_in", 32'(m_d_in), 32'h0);
    chk("rst_rsp", {23'd0, rsp_err, rsp_data}, 32'h0);
    rst = 1'b1;
    step();

    // Single transfer: req0, A5 to slave 1, engine returns 3C
    req_data[7:0] = 8'hA5; req_slv[2:0] = 3'd1; eng_rx = 8'h3C;
    n_start = 0; n_cs_low = 0; n_ack = 0;
    req = 4'b0001;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_cs_n", 32'(cs_n), 32'h1D);
    chk("t1_m_d_in", 32'(m_d_in), 32'hA5);
    chk("t1_start_early0", 32'(m_start), 32'h0);
    step();
    chk("t1_start_early1", 32'(m_start), 32'h0);
    step();
    chk("t1_start", 32'(m_start), 32'h1);
    until_ack("t1_ack_seen", 40, n);
    req = '0;
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_rsp_data", 32'(rsp_data), 32'h3C);
    chk("t1_rsp_err", 32'(rsp_err), 32'h0);
    chk("t1_cs_low_cycles", 32'(n_cs_low), 32'd12);
    chk("t1_cs_n_at_ack", 32'(cs_n), 32'h1F);
    chk("t1_gnt_at_ack", 32'(gnt), 32'h1);
    chk("t1_m_d_in_at_ack", 32'(m_d_in), 32'hA5);
    step();
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    chk("t1_ack_once", 32'(n_ack), 32'd1);
    chk("t1_start_once", 32'(n_start), 32'd1);

    // Reset mid-XFER: req2 to slave 2 moves ptr to 3 before the reset
    req_data[23:16] = 8'h77; req_slv[8:6] = 3'd2;
    req = 4'b0100;
    until_start("t4_start_seen", 10);
    step(); step();
    rst = 1'b0;
    n_ack = 0;
    step();
    chk("t4_cs_n", 32'(cs_n), 32'h1F);
    chk("t4_gnt", 32'(gnt), 32'h0);
    chk("t4_ack", 32'(ack), 32'h0);
    rst = 1'b1; req = '0; eng_cnt = 0;
    repeat (3) step();
    chk("t4_no_ack", 32'(n_ack), 32'd0);

    // Round robin from ptr=0 with all requests held
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_slv  = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_i = order[k];
      eng_rx = 8'hB0 + 8'(k);
      got = 1'b0; n = 0; hi = 0;
      while (!got && n < 20) begin
        step();
        n++;
        if (gnt !== '0) got = 1'b1;
        else if (cs_n === 5'h1F) hi++;
      end
      chk("rr_gnt_seen", 32'(got), 32'd1);
      chk("rr_gnt", 32'(gnt), 32'(1 << exp_i));
      chk("rr_cs_n", 32'(cs_n), 32'h1F & ~(32'(1) << exp_i));
      chk("rr_m_d_in", 32'(m_d_in), 32'h11 * 32'(exp_i + 1));
      if (k > 0) chk("rr_idle_high", 32'(hi), 32'd1);
      until_ack("rr_ack_seen", 40, n);
      if (k == 4) req = '0;
      chk("rr_ack", 32'(ack), 32'(1 << exp_i));
      chk("rr_rsp", 32'(rsp_data), 32'hB0 + 32'(k));
      chk("rr_cs_n_ack", 32'(cs_n), 32'h1F);
    end
    step();

    // Bad slave index: req2 with slave 5
    req_slv[8:6] = 3'd5;
    n_start = 0;
    req = 4'b0100;
    step();
    req = '0;
    chk("bad_gnt", 32'(gnt), 32'h4);
    chk("bad_ack", 32'(ack), 32'h4);
    chk("bad_err", 32'(rsp_err), 32'h1);
    chk("bad_rsp_keep", 32'(rsp_data), 32'hB4);
    chk("bad_cs_n", 32'(cs_n), 32'h1F);
    step();
    chk("bad_gnt_drop", 32'(gnt), 32'h0);
    chk("bad_ack_drop", 32'(ack), 32'h0);
    step(); step();
    chk("bad_no_start", 32'(n_start), 32'd0);
    req_slv[8:6] = 3'd2;

    // Spurious m_done in IDLE, then req1 dropped during XFER
    eng_rx = 8'hDD; eng_spur = 1'b1;
    step(); step();
    chk("spur_gnt", 32'(gnt), 32'h0);
    chk("spur_cs_n", 32'(cs_n), 32'h1F);
    chk("spur_rsp_keep", 32'(rsp_data), 32'hB4);
    req_data[15:8] = 8'h5A; req_slv[5:3] = 3'd0; eng_rx = 8'hC3;
    n_ack = 0;
    req = 4'b0010;
    until_start("drop_start_seen", 10);
    step(); step();
    req = '0;
    until_ack("drop_ack_seen", 40, n);
    chk("drop_ack", 32'(ack), 32'h2);
    chk("drop_rsp", 32'(rsp_data), 32'hC3);
    chk("drop_err", 32'(rsp_err), 32'h0);
    repeat (5) step();
    chk("drop_ack_once", 32'(n_ack), 32'd1);

`ifdef SPI_TIMEOUT_EN
    // Engine never answers: watchdog completes with error
    eng_on = 1'b0;
    req_data[31:24] = 8'h99; req_slv[11:9] = 3'd4;
    req = 4'b1000;
    until_start("tmo_start_seen", 10);
    until_ack("tmo_ack_seen", 200, n);
    req = '0;
    chk("tmo_cycles", 32'(n), 32'(TMO_CYC));
    chk("tmo_ack", 32'(ack), 32'h8);
    chk("tmo_err", 32'(rsp_err), 32'h1);
    chk("tmo_rsp_keep", 32'(rsp_data), 32'hC3);
    chk("tmo_cs_n", 32'(cs_n), 32'h1F);
    step();
    eng_on = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
